// File: rtl/dsp_stream_router.sv
// N-source ready/valid router (fixed, per-beat round-robin, burst round-robin) feeding a
// registered two-entry skid buffer. Per-source beat counters are built only with DSP_ROUTER_BEAT_CNT_EN.
module dsp_stream_router #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SRC    = 4,
    parameter int BURST_LEN  = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int ID_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    cfg_mode,
    input  logic [ID_W-1:0]               cfg_sel,
    input  logic [NUM_SRC-1:0]            cfg_en_mask,
    input  logic                          cnt_clear,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_in,
    input  logic [NUM_SRC-1:0]            src_valid_in,
    output logic [NUM_SRC-1:0]            src_ready_out,
    output logic [DATA_WIDTH-1:0]         dst_data_out,
    output logic [ID_W-1:0]               dst_id_out,
    output logic                          dst_last_out,
    output logic                          dst_valid_out,
    input  logic                          dst_ready_in,
    output logic [NUM_SRC*CNT_WIDTH-1:0]  beat_cnt_out,
    output logic                          busy_out
);
    localparam int BC_W  = $clog2(BURST_LEN + 1);
    localparam int PAD_W = 1 << ID_W;
    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_RR    = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic {ST_IDLE, ST_LOCK} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_W-1:0]       id;
        logic                  last;
    } beat_t;

    state_e               state_q, state_d;
    logic [1:0]           cfg_mode_q, cfg_mode_d;
    logic [ID_W-1:0]      cfg_sel_q, cfg_sel_d;
    logic [NUM_SRC-1:0]   cfg_en_mask_q, cfg_en_mask_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
    logic [BC_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 can_accept_q, can_accept_d;
    beat_t                mem_q [2];
    beat_t                mem_d [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;

    logic [NUM_SRC-1:0]   eligible;
    logic [PAD_W-1:0]     mask_pad;
    logic                 win_vld;
    logic [ID_W-1:0]      win_id;
    logic                 accept;
    logic                 pop;
    logic                 in_last;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_SRC - 1) ? '0 : id + 1'b1;
    endfunction

    assign eligible = cfg_en_mask_q & src_valid_in;
    assign mask_pad = PAD_W'(cfg_en_mask_q);

    // Winner selection; the lock overrides the registered mode and mask for the whole burst.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        if (state_q == ST_LOCK) begin
            win_vld = 1'b1;
            win_id  = lock_id_q;
        end else begin
            unique case (cfg_mode_q)
                MODE_FIXED: begin
                    win_vld = mask_pad[cfg_sel_q];
                    win_id  = cfg_sel_q;
                end
                MODE_RR, MODE_BURST: begin
                    // Walk backwards so the source closest to rr_ptr is the last one written.
                    for (int k = NUM_SRC - 1; k >= 0; k--) begin
                        idx = int'(rr_ptr_q) + k;
                        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                        if (eligible[idx]) begin
                            win_vld = 1'b1;
                            win_id  = ID_W'(idx);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        src_ready_out = '0;
        if (can_accept_q && win_vld) src_ready_out[win_id] = 1'b1;
    end

    assign accept        = can_accept_q & win_vld & src_valid_in[win_id];
    assign dst_valid_out = (count_q != 2'd0);
    assign pop           = dst_valid_out & dst_ready_in;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        in_last     = 1'b0;
        if (accept) begin
            if (state_q == ST_LOCK) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
                if (int'(burst_cnt_q) + 1 >= BURST_LEN) begin
                    in_last  = 1'b1;
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_id(lock_id_q);
                end
            end else if (cfg_mode_q == MODE_BURST) begin
                if (BURST_LEN == 1) begin
                    in_last  = 1'b1;
                    rr_ptr_d = next_id(win_id);
                end else begin
                    state_d     = ST_LOCK;
                    lock_id_d   = win_id;
                    burst_cnt_d = BC_W'(1);
                end
            end else if (cfg_mode_q == MODE_RR) begin
                rr_ptr_d = next_id(win_id);
            end
        end

        // Config is frozen while locked so a mid-burst change lands right after the last beat.
        cfg_mode_d    = (state_d == ST_LOCK) ? cfg_mode_q    : cfg_mode;
        cfg_sel_d     = (state_d == ST_LOCK) ? cfg_sel_q     : cfg_sel;
        cfg_en_mask_d = (state_d == ST_LOCK) ? cfg_en_mask_q : cfg_en_mask;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q].data = src_data_in[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
            mem_d[wr_ptr_q].id   = win_id;
            mem_d[wr_ptr_q].last = in_last;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d      = count_q + {1'b0, accept} - {1'b0, pop};
        can_accept_d = (count_d != 2'd2);
    end

    // NOTE: sequential state uses non-blocking assignments only; the next values come from always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cfg_mode_q    <= '0;
            cfg_sel_q     <= '0;
            cfg_en_mask_q <= '0;
            lock_id_q     <= '0;
            burst_cnt_q   <= '0;
            rr_ptr_q      <= '0;
            can_accept_q  <= 1'b0;
            // NOTE: the two buffer entries are reset so the data/id/last outputs read zero after reset.
            mem_q         <= '{default: '0};
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cfg_mode_q    <= cfg_mode_d;
            cfg_sel_q     <= cfg_sel_d;
            cfg_en_mask_q <= cfg_en_mask_d;
            lock_id_q     <= lock_id_d;
            burst_cnt_q   <= burst_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            can_accept_q  <= can_accept_d;
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    assign dst_data_out = mem_q[rd_ptr_q].data;
    assign dst_id_out   = mem_q[rd_ptr_q].id;
    assign dst_last_out = mem_q[rd_ptr_q].last;
    assign busy_out     = (state_q == ST_LOCK) || (count_q != 2'd0);

`ifdef DSP_ROUTER_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_SRC];

    // Saturating counters; a clear in the same cycle as a beat wins.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clear) begin
                cnt_d[i] = '0;
            end else if (accept && int'(win_id) == i && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_out
        assign beat_cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign beat_cnt_out     = '0;
`endif

endmodule
